// File: rtl/volley_pkg.sv
`default_nettype none
// ============================================================================
// volley_pkg : playfield geometry, datapath widths and game-state encoding
//              shared by the ball engine and the player blocks.
// Revision   : 1.0
// ============================================================================
package volley_pkg;
    localparam int COORD_W  = 10;
    localparam int VEL_W    = 11;
    localparam int POS_W    = 12;
    localparam int SCREEN_W = 320;
    localparam int GROUND_Y = 200;
    localparam int NET_X    = 160;
    localparam int NET_HW   = 4;
    localparam int NET_TOP  = 136;

    typedef enum logic [1:0] {
        SERVE  = 2'd0,
        PLAY   = 2'd1,
        SCORED = 2'd2
    } game_state_t;

    typedef logic signed [VEL_W-1:0] vel_t;
    typedef logic signed [POS_W-1:0] pos_t;

    function automatic pos_t to_pos(input logic [COORD_W-1:0] c);
        return pos_t'({{(POS_W-COORD_W){1'b0}}, c});
    endfunction
endpackage
`default_nettype wire

// File: rtl/ball_player_hit.sv
`default_nettype none
// ============================================================================
// ball_player_hit : hit-box test of the ball against one player and the
//                   velocity the ball leaves with (normal bounce or smash).
// Revision        : 1.0
// ============================================================================
module ball_player_hit
    import volley_pkg::*;
#(
    parameter bit SMASH_RIGHT = 1'b1,
    parameter int HIT_DX      = 24,
    parameter int HIT_DY      = 32,
    parameter int BOUNCE_VY   = 12,
    parameter int SMASH_VX    = 10,
    parameter int SMASH_VY    = 8
) (
    input  logic [COORD_W-1:0]      ball_x,
    input  logic [COORD_W-1:0]      ball_y,
    input  logic signed [VEL_W-1:0] vel_y,
    input  logic [COORD_W-1:0]      px,
    input  logic [COORD_W-1:0]      py,
    input  logic                    smash,
    output logic                    hit,
    output logic signed [VEL_W-1:0] hit_vx,
    output logic signed [VEL_W-1:0] hit_vy
);
    pos_t dx, dy, adx, ady, dx_q;

    always_comb begin
        dx   = to_pos(ball_x) - to_pos(px);
        dy   = to_pos(ball_y) - to_pos(py);
        adx  = dx[POS_W-1] ? -dx : dx;
        ady  = dy[POS_W-1] ? -dy : dy;
        dx_q = dx >>> 2;
        // Only a falling ball can be struck.
        hit  = (adx < pos_t'(HIT_DX)) && (ady < pos_t'(HIT_DY)) &&
               !vel_y[VEL_W-1] && (vel_y != vel_t'(0));
        if (smash) begin
            hit_vx = SMASH_RIGHT ? vel_t'(SMASH_VX) : -vel_t'(SMASH_VX);
            hit_vy = vel_t'(SMASH_VY);
        end else begin
            hit_vx = vel_t'(dx_q);
            hit_vy = -vel_t'(BOUNCE_VY);
        end
    end
endmodule
`default_nettype wire

// File: rtl/ball_physics.sv
`default_nettype none
// ============================================================================
// ball_physics : per-frame ball engine - gravity, wall/net/ground/player
//                collisions, point events and the serve/rally/freeze sequence.
// Revision     : 1.0
// ============================================================================
module ball_physics
    import volley_pkg::*;
#(
    parameter int BALL_R        = 8,
    parameter int GRAVITY       = 1,
    parameter int MAX_VY        = 15,
    parameter int HIT_DX        = 24,
    parameter int HIT_DY        = 32,
    parameter int BOUNCE_VY     = 12,
    parameter int SMASH_VX      = 10,
    parameter int SMASH_VY      = 8,
    parameter int SERVE_X_P1    = 60,
    parameter int SERVE_X_P2    = 260,
    parameter int SERVE_Y       = 40,
    parameter int FREEZE_FRAMES = 45
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [COORD_W-1:0] p1_x,
    input  logic [COORD_W-1:0] p1_y,
    input  logic               p1_smash,
    input  logic [COORD_W-1:0] p2_x,
    input  logic [COORD_W-1:0] p2_y,
    input  logic               p2_smash,
    output logic [COORD_W-1:0] ball_x,
    output logic [COORD_W-1:0] ball_y,
    output logic               rally_active,
    output logic               point_p1,
    output logic               point_p2
);
    localparam int   FC_W      = $clog2(FREEZE_FRAMES + 1);
    localparam pos_t X_MIN     = pos_t'(BALL_R);
    localparam pos_t X_MAX     = pos_t'(SCREEN_W - 1 - BALL_R);
    localparam pos_t FLOOR_Y   = pos_t'(GROUND_Y - BALL_R);
    localparam pos_t NET_LIM_Y = pos_t'(NET_TOP - BALL_R);
    localparam pos_t NET_XP    = pos_t'(NET_X);
    localparam pos_t NET_REACH = pos_t'(NET_HW + BALL_R);

    game_state_t        state, state_nx;
    logic               server, server_nx;      // 0: P1 serves, 1: P2 serves
    vel_t               vel_x, vel_y, vel_x_nx, vel_y_nx;
    logic [COORD_W-1:0] ball_x_nx, ball_y_nx;
    logic [FC_W-1:0]    freeze_cnt, freeze_cnt_nx;
    logic               point_p1_nx, point_p2_nx;

    pos_t               nx, ny, net_dx, net_adx;
    vel_t               vy_inc, nvy;
    logic [COORD_W-1:0] cx, cy, serve_x;
    logic               wall, net_hit;
    logic               hit1, hit2;
    vel_t               hit1_vx, hit1_vy, hit2_vx, hit2_vy;

    ball_player_hit #(
        .SMASH_RIGHT(1'b1), .HIT_DX(HIT_DX), .HIT_DY(HIT_DY),
        .BOUNCE_VY(BOUNCE_VY), .SMASH_VX(SMASH_VX), .SMASH_VY(SMASH_VY)
    ) u_hit_p1 (
        .ball_x(ball_x), .ball_y(ball_y), .vel_y(vel_y),
        .px(p1_x), .py(p1_y), .smash(p1_smash),
        .hit(hit1), .hit_vx(hit1_vx), .hit_vy(hit1_vy)
    );

    ball_player_hit #(
        .SMASH_RIGHT(1'b0), .HIT_DX(HIT_DX), .HIT_DY(HIT_DY),
        .BOUNCE_VY(BOUNCE_VY), .SMASH_VX(SMASH_VX), .SMASH_VY(SMASH_VY)
    ) u_hit_p2 (
        .ball_x(ball_x), .ball_y(ball_y), .vel_y(vel_y),
        .px(p2_x), .py(p2_y), .smash(p2_smash),
        .hit(hit2), .hit_vx(hit2_vx), .hit_vy(hit2_vy)
    );

    always_comb begin
        nx     = to_pos(ball_x) + pos_t'(vel_x);
        ny     = to_pos(ball_y) + pos_t'(vel_y);
        vy_inc = vel_y + vel_t'(GRAVITY);
        if (vy_inc > vel_t'(MAX_VY))
            nvy = vel_t'(MAX_VY);
        else if (vy_inc < -vel_t'(MAX_VY))
            nvy = -vel_t'(MAX_VY);
        else
            nvy = vy_inc;

        net_dx  = nx - NET_XP;
        net_adx = net_dx[POS_W-1] ? -net_dx : net_dx;
        net_hit = (ny > NET_LIM_Y) && (net_adx < NET_REACH);
        wall    = (nx < X_MIN) || (nx > X_MAX);

        if (nx < X_MIN)
            cx = X_MIN[COORD_W-1:0];
        else if (nx > X_MAX)
            cx = X_MAX[COORD_W-1:0];
        else
            cx = nx[COORD_W-1:0];
        // No ceiling: a ball thrown above the screen top is pinned at row 0.
        cy = ny[POS_W-1] ? '0 : ny[COORD_W-1:0];

        serve_x = server ? COORD_W'(SERVE_X_P2) : COORD_W'(SERVE_X_P1);
    end

    always_comb begin
        state_nx      = state;
        server_nx     = server;
        ball_x_nx     = ball_x;
        ball_y_nx     = ball_y;
        vel_x_nx      = vel_x;
        vel_y_nx      = vel_y;
        freeze_cnt_nx = freeze_cnt;
        point_p1_nx   = 1'b0;
        point_p2_nx   = 1'b0;

        case (state)
            SERVE: begin
                ball_x_nx = serve_x;
                ball_y_nx = COORD_W'(SERVE_Y);
                vel_x_nx  = '0;
                vel_y_nx  = '0;
                if (start)
                    state_nx = PLAY;
            end
            PLAY: begin
                if (ny >= FLOOR_Y) begin
                    ball_x_nx     = cx;
                    ball_y_nx     = FLOOR_Y[COORD_W-1:0];
                    vel_x_nx      = '0;
                    vel_y_nx      = '0;
                    state_nx      = SCORED;
                    freeze_cnt_nx = FC_W'(FREEZE_FRAMES - 1);
                    if (nx < NET_XP) begin
                        point_p2_nx = 1'b1;
                        server_nx   = 1'b1;
                    end else begin
                        point_p1_nx = 1'b1;
                        server_nx   = 1'b0;
                    end
                end else if (hit1 || hit2) begin
                    ball_x_nx = cx;
                    ball_y_nx = cy;
                    vel_x_nx  = hit1 ? hit1_vx : hit2_vx;
                    vel_y_nx  = hit1 ? hit1_vy : hit2_vy;
                end else if (net_hit) begin
                    ball_x_nx = (ball_x < COORD_W'(NET_X)) ? COORD_W'(NET_X - NET_HW - BALL_R)
                                                           : COORD_W'(NET_X + NET_HW + BALL_R);
                    ball_y_nx = cy;
                    vel_x_nx  = -vel_x;
                    vel_y_nx  = nvy;
                end else if (wall) begin
                    ball_x_nx = cx;
                    ball_y_nx = cy;
                    vel_x_nx  = -vel_x;
                    vel_y_nx  = nvy;
                end else begin
                    ball_x_nx = cx;
                    ball_y_nx = cy;
                    vel_y_nx  = nvy;
                end
            end
            SCORED: begin
                if (freeze_cnt == '0) begin
                    state_nx  = SERVE;
                    ball_x_nx = serve_x;
                    ball_y_nx = COORD_W'(SERVE_Y);
                end else begin
                    freeze_cnt_nx = freeze_cnt - 1'b1;
                end
            end
            default: state_nx = SERVE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= SERVE;
            server     <= 1'b0;
            ball_x     <= COORD_W'(SERVE_X_P1);
            ball_y     <= COORD_W'(SERVE_Y);
            vel_x      <= '0;
            vel_y      <= '0;
            freeze_cnt <= '0;
            point_p1   <= 1'b0;
            point_p2   <= 1'b0;
        end else begin
            state      <= state_nx;
            server     <= server_nx;
            ball_x     <= ball_x_nx;
            ball_y     <= ball_y_nx;
            vel_x      <= vel_x_nx;
            vel_y      <= vel_y_nx;
            freeze_cnt <= freeze_cnt_nx;
            point_p1   <= point_p1_nx;
            point_p2   <= point_p2_nx;
        end
    end

    assign rally_active = (state == PLAY);
endmodule
`default_nettype wire

// File: tb/tb_ball_physics.sv
`default_nettype none
// ============================================================================
// tb_ball_physics : directed scenarios for the ball engine with hand-computed
//                   trajectories; velocities are inferred from position steps.
// Revision        : 1.0
// ============================================================================
module tb_ball_physics;
    logic       clk, rst_n, start;
    logic [9:0] p1_x, p1_y, p2_x, p2_y;
    logic       p1_smash, p2_smash;
    logic [9:0] ball_x, ball_y;
    logic       rally_active, point_p1, point_p2;
    int         total = 0;
    int         bad   = 0;

    ball_physics dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .p1_x(p1_x), .p1_y(p1_y), .p1_smash(p1_smash),
        .p2_x(p2_x), .p2_y(p2_y), .p2_smash(p2_smash),
        .ball_x(ball_x), .ball_y(ball_y), .rally_active(rally_active),
        .point_p1(point_p1), .point_p2(point_p2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic park();
        p1_x = 10'd900; p1_y = 10'd0; p1_smash = 1'b0;
        p2_x = 10'd900; p2_y = 10'd0; p2_smash = 1'b0;
    endtask

    // Release the serve and let the ball fall 5 frames: ends at y=50, vy=+5.
    task automatic serve_and_fall5();
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (5) step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; park();
        repeat (2) step();
        total++; if (ball_x !== 10'd60 || ball_y !== 10'd40) begin bad++; $display("FAIL reset_pos: got (%0d,%0d) expected (60,40)", ball_x, ball_y); end
        total++; if ({rally_active, point_p1, point_p2} !== 3'b000) begin bad++; $display("FAIL reset_flags: got %b expected 000", {rally_active, point_p1, point_p2}); end
        rst_n = 1'b1;
        repeat (2) step();
        total++; if (ball_x !== 10'd60 || ball_y !== 10'd40 || rally_active !== 1'b0) begin bad++; $display("FAIL serve_hold: got (%0d,%0d) rally=%b expected (60,40) rally=0", ball_x, ball_y, rally_active); end
    endtask

    task automatic test_serve_fall();
        int exp_y [4] = '{40, 41, 43, 46};
        start = 1'b1;
        step();
        start = 1'b0;
        total++; if (ball_y !== 10'd40 || rally_active !== 1'b1) begin bad++; $display("FAIL serve_release: got y=%0d rally=%b expected y=40 rally=1", ball_y, rally_active); end
        for (int i = 0; i < 4; i++) begin
            step();
            total++; if (ball_x !== 10'd60 || ball_y !== 10'(exp_y[i])) begin bad++; $display("FAIL fall_%0d: got (%0d,%0d) expected (60,%0d)", i, ball_x, ball_y, exp_y[i]); end
        end
        total++; if (rally_active !== 1'b1) begin bad++; $display("FAIL rally_active: got %b expected 1", rally_active); end
    endtask

    task automatic test_ground_point();
        repeat (14) step();
        total++; if (ball_y !== 10'd190 || point_p1 !== 1'b0 || point_p2 !== 1'b0) begin bad++; $display("FAIL pre_ground: got y=%0d p1=%b p2=%b expected y=190 p1=0 p2=0", ball_y, point_p1, point_p2); end
        step();
        total++; if (ball_x !== 10'd60 || ball_y !== 10'd192) begin bad++; $display("FAIL ground_pos: got (%0d,%0d) expected (60,192)", ball_x, ball_y); end
        total++; if ({point_p1, point_p2, rally_active} !== 3'b010) begin bad++; $display("FAIL ground_point: got p1/p2/rally=%b expected 010", {point_p1, point_p2, rally_active}); end
        start = 1'b1;
        step();
        total++; if (point_p2 !== 1'b0 || point_p1 !== 1'b0) begin bad++; $display("FAIL pulse_width: got p1=%b p2=%b expected 0 0", point_p1, point_p2); end
        repeat (43) step();
        total++; if (ball_x !== 10'd60 || ball_y !== 10'd192 || rally_active !== 1'b0) begin bad++; $display("FAIL freeze_hold: got (%0d,%0d) rally=%b expected (60,192) rally=0", ball_x, ball_y, rally_active); end
        step();
        total++; if (ball_x !== 10'd260 || ball_y !== 10'd40 || rally_active !== 1'b0) begin bad++; $display("FAIL reserve_p2: got (%0d,%0d) rally=%b expected (260,40) rally=0", ball_x, ball_y, rally_active); end
        start = 1'b0;
        step();
        total++; if (ball_x !== 10'd260 || ball_y !== 10'd40 || rally_active !== 1'b0) begin bad++; $display("FAIL serve_wait: got (%0d,%0d) rally=%b expected (260,40) rally=0", ball_x, ball_y, rally_active); end
    endtask

    // Hit geometry: ball 4 px left of and 20 px above P2 -> vx=-1, vy=-12.
    task automatic test_normal_hit();
        int n = 0;
        serve_and_fall5();
        total++; if (ball_x !== 10'd260 || ball_y !== 10'd50) begin bad++; $display("FAIL p2_fall: got (%0d,%0d) expected (260,50)", ball_x, ball_y); end
        p2_x = 10'd264; p2_y = 10'd70;
        step();
        park();
        total++; if (ball_x !== 10'd260 || ball_y !== 10'd55) begin bad++; $display("FAIL hit_frame: got (%0d,%0d) expected (260,55)", ball_x, ball_y); end
        step();
        total++; if (ball_x !== 10'd259 || ball_y !== 10'd43) begin bad++; $display("FAIL bounce_1: got (%0d,%0d) expected (259,43)", ball_x, ball_y); end
        step();
        total++; if (ball_x !== 10'd258 || ball_y !== 10'd32) begin bad++; $display("FAIL bounce_2: got (%0d,%0d) expected (258,32)", ball_x, ball_y); end
        while (!(point_p1 || point_p2) && n < 200) begin step(); n++; end
        total++; if (n >= 200) begin bad++; $display("FAIL hit_rally_end: got no point in %0d frames expected one", n); end
        total++; if (point_p1 !== 1'b1 || point_p2 !== 1'b0) begin bad++; $display("FAIL hit_rally_winner: got p1=%b p2=%b expected p1=1 p2=0", point_p1, point_p2); end
        repeat (45) step();
        total++; if (ball_x !== 10'd60 || ball_y !== 10'd40) begin bad++; $display("FAIL reserve_p1: got (%0d,%0d) expected (60,40)", ball_x, ball_y); end
    endtask

    task automatic test_smash();
        serve_and_fall5();
        total++; if (ball_x !== 10'd60 || ball_y !== 10'd50) begin bad++; $display("FAIL p1_fall: got (%0d,%0d) expected (60,50)", ball_x, ball_y); end
        p2_x = 10'd64; p2_y = 10'd70; p2_smash = 1'b1;
        step();
        park();
        total++; if (ball_x !== 10'd60 || ball_y !== 10'd55) begin bad++; $display("FAIL smash_frame: got (%0d,%0d) expected (60,55)", ball_x, ball_y); end
        step();
        total++; if (ball_x !== 10'd50 || ball_y !== 10'd63) begin bad++; $display("FAIL smash_move: got (%0d,%0d) expected (50,63)", ball_x, ball_y); end
    endtask

    // Continues the smash rally: vx=-10 runs into the left wall.
    task automatic test_wall();
        repeat (4) step();
        total++; if (ball_x !== 10'd10 || ball_y !== 10'd105) begin bad++; $display("FAIL pre_wall: got (%0d,%0d) expected (10,105)", ball_x, ball_y); end
        step();
        total++; if (ball_x !== 10'd8 || ball_y !== 10'd118) begin bad++; $display("FAIL wall_clamp: got (%0d,%0d) expected (8,118)", ball_x, ball_y); end
        step();
        total++; if (ball_x !== 10'd18 || ball_y !== 10'd132) begin bad++; $display("FAIL wall_rebound: got (%0d,%0d) expected (18,132)", ball_x, ball_y); end
        repeat (4) step();
        total++; if (ball_x !== 10'd58 || ball_y !== 10'd192 || point_p2 !== 1'b1 || point_p1 !== 1'b0) begin bad++; $display("FAIL wall_land: got (%0d,%0d) p1=%b p2=%b expected (58,192) p1=0 p2=1", ball_x, ball_y, point_p1, point_p2); end
        repeat (45) step();
        total++; if (ball_x !== 10'd260 || ball_y !== 10'd40) begin bad++; $display("FAIL wall_reserve: got (%0d,%0d) expected (260,40)", ball_x, ball_y); end
    endtask

    task automatic test_net_right();
        serve_and_fall5();
        p2_x = 10'd264; p2_y = 10'd70; p2_smash = 1'b1;
        step();
        park();
        repeat (8) step();
        total++; if (ball_x !== 10'd180 || ball_y !== 10'd147) begin bad++; $display("FAIL netr_approach: got (%0d,%0d) expected (180,147)", ball_x, ball_y); end
        step();
        total++; if (ball_x !== 10'd172 || ball_y !== 10'd162) begin bad++; $display("FAIL netr_clamp: got (%0d,%0d) expected (172,162)", ball_x, ball_y); end
        step();
        total++; if (ball_x !== 10'd182 || ball_y !== 10'd177) begin bad++; $display("FAIL netr_rebound: got (%0d,%0d) expected (182,177)", ball_x, ball_y); end
        step();
        total++; if (ball_x !== 10'd192 || point_p1 !== 1'b1 || point_p2 !== 1'b0) begin bad++; $display("FAIL netr_land: got x=%0d p1=%b p2=%b expected x=192 p1=1 p2=0", ball_x, point_p1, point_p2); end
        repeat (45) step();
    endtask

    task automatic test_net_left();
        serve_and_fall5();
        p1_x = 10'd56; p1_y = 10'd70; p1_smash = 1'b1;
        step();
        park();
        repeat (8) step();
        total++; if (ball_x !== 10'd140 || ball_y !== 10'd147) begin bad++; $display("FAIL netl_approach: got (%0d,%0d) expected (140,147)", ball_x, ball_y); end
        step();
        total++; if (ball_x !== 10'd148 || ball_y !== 10'd162) begin bad++; $display("FAIL netl_clamp: got (%0d,%0d) expected (148,162)", ball_x, ball_y); end
        step();
        total++; if (ball_x !== 10'd138 || ball_y !== 10'd177) begin bad++; $display("FAIL netl_rebound: got (%0d,%0d) expected (138,177)", ball_x, ball_y); end
        step();
        total++; if (ball_x !== 10'd128 || point_p2 !== 1'b1 || point_p1 !== 1'b0) begin bad++; $display("FAIL netl_land: got x=%0d p1=%b p2=%b expected x=128 p1=0 p2=1", ball_x, point_p1, point_p2); end
        repeat (45) step();
        total++; if (ball_x !== 10'd260 || ball_y !== 10'd40) begin bad++; $display("FAIL netl_reserve: got (%0d,%0d) expected (260,40)", ball_x, ball_y); end
    endtask

    task automatic test_reset_mid_play();
        int n = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        total++; if (ball_x !== 10'd260 || ball_y !== 10'd43 || rally_active !== 1'b1) begin bad++; $display("FAIL mid_play: got (%0d,%0d) rally=%b expected (260,43) rally=1", ball_x, ball_y, rally_active); end
        #3 rst_n = 1'b0;
        #1;
        total++; if (ball_x !== 10'd60 || ball_y !== 10'd40 || {rally_active, point_p1, point_p2} !== 3'b000) begin bad++; $display("FAIL async_reset: got (%0d,%0d) flags=%b expected (60,40) flags=000", ball_x, ball_y, {rally_active, point_p1, point_p2}); end
        step();
        rst_n = 1'b1;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        while (!(point_p1 || point_p2) && n < 40) begin step(); n++; end
        total++; if (n >= 40 || point_p2 !== 1'b1 || ball_x !== 10'd60) begin bad++; $display("FAIL post_reset_rally: got frames=%0d x=%0d p2=%b expected point_p2 at x=60", n, ball_x, point_p2); end
        #3 rst_n = 1'b0;
        #1;
        total++; if (point_p1 !== 1'b0 || point_p2 !== 1'b0 || ball_y !== 10'd40) begin bad++; $display("FAIL pulse_reset: got p1=%b p2=%b y=%0d expected 0 0 40", point_p1, point_p2, ball_y); end
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_serve_fall();
        test_ground_point();
        test_normal_hit();
        test_smash();
        test_wall();
        test_net_right();
        test_net_left();
        test_reset_mid_play();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
